// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 codec serial interface blocks.
package wm8731_pkg;

  localparam int unsigned FRAME_BITS   = 32;
  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned LR_HALF_BITS = 32;
  localparam int unsigned BIT_CNT_W    = $clog2(2 * LR_HALF_BITS);
  localparam int unsigned CAP_CNT_W    = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    WAIT    = 2'd3
  } rx_state_e;

  // One stereo frame as it arrives on the wire: left half is sent first.
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/codec_clk_gen.sv
// Bit clock and frame clock generator for the codec serial port; also
// provides the b_clk falling strobe and the frame-clock rise strobe.
module codec_clk_gen #(
  parameter int unsigned BCLK_DIV = 2
) (
  input  logic m_clk,
  input  logic rst,
  input  logic clr,
  output logic b_clk,
  output logic adc_lr_clk,
  output logic fall_c,
  output logic lr_rise_c
);
  import wm8731_pkg::*;

  localparam int unsigned HALF_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [HALF_W-1:0]    HALF_LAST = HALF_W'(BCLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_MID   = BIT_CNT_W'(LR_HALF_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(2 * LR_HALF_BITS - 1);

  logic [HALF_W-1:0]    half_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 wrap_c;

  assign wrap_c    = (half_cnt == HALF_LAST);
  assign fall_c    = !clr && wrap_c && b_clk;
  assign lr_rise_c = fall_c && (bit_cnt == BIT_LAST);

  // All frame-clock edges are taken on b_clk falls so they stay aligned.
  always_ff @(posedge m_clk) begin
    if (rst || clr) begin
      half_cnt   <= '0;
      bit_cnt    <= '0;
      b_clk      <= 1'b0;
      adc_lr_clk <= 1'b0;
    end else begin
      if (wrap_c) begin
        half_cnt <= '0;
        b_clk    <= ~b_clk;
      end else begin
        half_cnt <= half_cnt + HALF_W'(1);
      end
      if (fall_c) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        if (bit_cnt == BIT_LAST) begin
          adc_lr_clk <= 1'b1;
        end else if (bit_cnt == BIT_MID) begin
          adc_lr_clk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/adc_rx.sv
// WM8731 ADC receive path: frame-aligned serial capture of adcdat into
// left/right samples with a valid/ready output and overrun flag.
module adc_rx #(
  parameter int unsigned BCLK_DIV = 2,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                m_clk,
  input  logic                rst,
  input  logic                en,
  input  logic                adcdat,
  output logic                b_clk,
  output logic                adc_lr_clk,
  output logic [SAMPLE_W-1:0] left,
  output logic [SAMPLE_W-1:0] right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun
);
  import wm8731_pkg::*;

  localparam logic [CAP_CNT_W-1:0] CAP_LAST = CAP_CNT_W'(FRAME_BITS - 1);

  rx_state_e              state;
  rx_state_e              state_nxt;
  logic [CAP_CNT_W-1:0]   cap_cnt;
  logic [FRAME_BITS-1:0]  shift_q;
  logic [FRAME_BITS-1:0]  frame_c;
  sample_pair_t           pair_c;
  logic                   gen_clr_c;
  logic                   fall_c;
  logic                   lr_rise_c;
  logic                   shift_en_c;
  logic                   load_c;

  // Generator only runs while enabled and out of IDLE, so it restarts from zero.
  assign gen_clr_c = !en || (state == IDLE);

  codec_clk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .m_clk      (m_clk),
    .rst        (rst),
    .clr        (gen_clr_c),
    .b_clk      (b_clk),
    .adc_lr_clk (adc_lr_clk),
    .fall_c     (fall_c),
    .lr_rise_c  (lr_rise_c)
  );

  assign frame_c = {shift_q[FRAME_BITS-2:0], adcdat};
  assign pair_c  = sample_pair_t'(frame_c);

  always_ff @(posedge m_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture starts only on a frame-clock rise, discarding any partial frame.
  always_comb begin
    state_nxt  = state;
    shift_en_c = 1'b0;
    load_c     = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = ARM;
      end
      ARM: begin
        if (lr_rise_c) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (fall_c) begin
          shift_en_c = 1'b1;
          if (cap_cnt == CAP_LAST) begin
            load_c    = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (lr_rise_c) state_nxt = CAPTURE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!en) begin
      state_nxt  = IDLE;
      shift_en_c = 1'b0;
      load_c     = 1'b0;
    end
  end

  always_ff @(posedge m_clk) begin
    if (rst) begin
      cap_cnt <= '0;
      shift_q <= '0;
    end else begin
      if (state != CAPTURE) begin
        cap_cnt <= '0;
      end else if (shift_en_c) begin
        cap_cnt <= cap_cnt + CAP_CNT_W'(1);
      end
      if (shift_en_c) begin
        shift_q <= frame_c;
      end
    end
  end

  // A load always wins over a handshake; overrun only when the old frame is lost.
  always_ff @(posedge m_clk) begin
    if (rst) begin
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= load_c && sample_valid && !sample_ready;
      if (load_c) begin
        left         <= pair_c.left;
        right        <= pair_c.right;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adc_rx.md
# adc_rx

Receive-side serial interface of the WM8731 codec controller. Generates the codec bit clock `b_clk` and ADC frame clock `adc_lr_clk` from the master clock, and captures the serial `adcdat` stream driven by the codec. Each captured stereo frame is delivered as a 16-bit left / 16-bit right sample pair over a valid/ready handshake. The block sits directly between the codec ADC pins and the controller's sample datapath.

## Interface
Parameters:
- `BCLK_DIV`, 2: `m_clk` cycles per half `b_clk` period. Must be at least 1. `b_clk` frequency is `m_clk / (2*BCLK_DIV)`.
- `SAMPLE_W`, 16: width of each channel sample. `2*SAMPLE_W` must equal `FRAME_BITS` (32).

Ports:
- `m_clk`, in, 1: single system clock. Every register in the block is clocked by it.
- `rst`, in, 1: reset, synchronous and active-high.
- `en`, in, 1: run enable. When low, the block is held idle with clocks parked low.
- `adcdat`, in, 1: serial ADC data from the codec, MSB first.
- `b_clk`, out, 1: generated bit clock. Registered.
- `adc_lr_clk`, out, 1: generated frame clock. High for 32 `b_clk` periods, then low for 32. Registered.
- `left`, out, SAMPLE_W: left sample, taken from frame bits 31..16.
- `right`, out, SAMPLE_W: right sample, taken from frame bits 15..0.
- `sample_valid`, out, 1: `left`/`right` hold an unconsumed frame.
- `sample_ready`, in, 1: the consumer accepts the frame.
- `overrun`, out, 1: one-cycle pulse when a completed frame overwrites an unconsumed one.

## Operation
- Reset values: `b_clk`=0, `adc_lr_clk`=0, `left`=0, `right`=0, `sample_valid`=0, `overrun`=0. All counters are cleared and the FSM is in IDLE.
- Clock generation:
  - A half-period counter counts 0..`BCLK_DIV`-1. `b_clk` toggles on wrap.
  - A bit counter (6 bits) advances on every `b_clk` falling toggle, counting 0..63 and wrapping.
  - `adc_lr_clk` rises on the fall where the bit counter wraps 63→0, and falls on the fall where it goes 31→32.
- The codec changes `adcdat` on `b_clk` rising edges. The first rise after an `adc_lr_clk` rise carries bit 31.
- Capture strobe: asserted in the `m_clk` cycle in which `b_clk` is registered 1→0. On a strobe, `adcdat` is shifted into a 32-bit shift register from the LSB side.
- FSM states:
  - IDLE: generator is stopped and outputs are low. Go to ARM when `en`=1.
  - ARM: generator runs, nothing is captured. Go to CAPTURE on the `adc_lr_clk` rise. This discards any partial first frame.
  - CAPTURE: take 32 capture strobes, counting 0..31. Strobe #1 is the first falling edge after the `lr` rise, and strobe #32 coincides with the `lr` fall. After strobe #32:
    - Load `left`/`right` from the shift register.
    - Set `sample_valid`.
    - Go to WAIT.
  - WAIT: go to CAPTURE on the next `adc_lr_clk` rise.
  - From any state, `en`=0 returns to IDLE in the next cycle, clears the generator, and drops any partial frame. A frame already in `left`/`right` with `sample_valid`=1 is retained.
- Handshake:
  - `sample_valid` clears in the cycle after `sample_valid && sample_ready`.
  - The output registers change only on frame load.
  - If a load coincides with `sample_valid`=1 and `sample_ready`=0, the new frame overwrites the old one, `sample_valid` stays 1, and `overrun` pulses.
  - If a load coincides with a handshake, the handshake consumes the old frame, the new frame loads, and `sample_valid` stays 1 with no `overrun`.
- `rst` has priority over everything, including mid-frame. It returns all outputs to their reset values in the next cycle.

## Timing
- `b_clk` and `adc_lr_clk` change only on `m_clk` edges and are glitch-free registers.
- `adc_lr_clk` edges are coincident, in the same `m_clk` cycle, with `b_clk` falling.
- Capture latency: `left`, `right` and `sample_valid` update in the `m_clk` cycle after strobe #32.
- Frame period: 64 × 2 × `BCLK_DIV` `m_clk` cycles, which is 256 at the default.
- From `en` rising to the first `sample_valid`: one full `lr` period to reach the first `lr` rise, plus 32 `b_clk` periods.

## Structure
- Shared package `wm8731_pkg` holds:
  - `FRAME_BITS`=32.
  - `SAMPLE_W`=16.
  - `LR_HALF_BITS`=32.
  - The FSM state enum (IDLE, ARM, CAPTURE, WAIT).
- One natural sub-module, `codec_clk_gen`. It takes `BCLK_DIV` and produces the `b_clk` and `adc_lr_clk` registers, the capture strobe, and an `lr` rise strobe. It is reusable for the DAC path.
- The top level contains the FSM, the shift register and the output handshake.

## Test plan
- Reset, then `en`=1, `BCLK_DIV`=2 → `b_clk` period is 4 `m_clk` cycles, `adc_lr_clk` period is 256 `m_clk` cycles with a 50% duty, and `adc_lr_clk` edges fall on `b_clk` falling cycles.
- Codec model sends 0xA5A53C3C after an `lr` rise, with `sample_ready`=1 → `left`=0xA5A5 and `right`=0x3C3C. `sample_valid` goes high one cycle after strobe #32 and drops the cycle after the handshake.
- Two frames, 0x12345678 then 0xFFFF0000, with `sample_ready`=0 → at the second load, `overrun` pulses once and outputs read 0xFFFF / 0x0000 with `sample_valid` still 1.
- `en` raised mid-`lr`-period while the codec sends 0xDEADBEEF every frame → the first partial frame is discarded, and the first valid output is `left`=0xDEAD, `right`=0xBEEF.
- `rst` asserted after 10 bits of CAPTURE → the next cycle shows all outputs 0. With `en` still high, the FSM re-arms, and the next complete frame is captured correctly.
- `sample_ready` asserted in the same cycle as a new frame load while `sample_valid`=1 → no `overrun`, the new frame is presented, and `sample_valid` remains 1.
